// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the uart_tx arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_WORD_W      = 32;
  localparam int UART_DEF_TIMEOUT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and uart_tx side signals of the arbiter. The slave
//            modport is the arbiter's view, the master modport the
//            environment's view (requesters plus uart_tx).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_WORD_W
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        done;
  logic                      txd_en;
  logic [DATA_W-1:0]         txd_data;
  logic                      txd_flag;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
  logic                      timeout_err;

  modport slave (
    input  req, req_data, txd_flag,
    output done, txd_en, txd_data, busy, grant_id, timeout_err
  );

  modport master (
    output req, req_data, txd_flag,
    input  done, txd_en, txd_data, busy, grant_id, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : uart_rr_pick
// Brief    : Combinational round-robin picker. Returns the first set request
//            found searching upward from last+1, wrapping modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    any    = |req;
    idx    = '0;
    w_cand = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one uart_tx among NUM_REQ word
//            producers. Latches the winner's word, pulses txd_en, waits for
//            txd_flag, pulses done to the winner, then rotates priority.
//            Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a
//            transfer that sees no txd_flag within TIMEOUT_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_WORD_W,
  parameter int TIMEOUT_CYC = UART_DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [DATA_W-1:0]  r_txd_data;
  logic [NUM_REQ-1:0] r_done;
  logic               r_txd_en;
  logic               r_busy;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (bus.req),
    .last (r_last),
    .any  (w_pick_any),
    .idx  (w_pick_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        w_wd_hit;
  logic        w_timeout;
  logic        r_timeout_err;

  assign w_wd_hit = (r_wd_cnt == 32'(TIMEOUT_CYC - 1));

  // Watchdog counts WAIT cycles; cleared while launching so it starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_wd_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  // Error pulse coincides with the DONE cycle of an aborted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  // Watchdog not built: the error output is a constant zero.
  assign bus.timeout_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; txd_flag only matters while waiting.
  always_comb begin
    w_next = r_state;
`ifdef UART_ARB_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      IDLE:    if (w_pick_any) w_next = LAUNCH;
      LAUNCH:  w_next = WAIT;
      WAIT: begin
        if (bus.txd_flag) begin
          w_next = DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (w_wd_hit) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
`endif
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= '0;
      r_grant    <= '0;
      r_txd_data <= '0;
      r_last     <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_txd_en <= (w_next == LAUNCH);
      r_busy   <= (w_next != IDLE);
      r_done   <= '0;
      if (r_state == IDLE && w_pick_any) begin
        r_grant    <= w_pick_idx;
        r_txd_data <= bus.req_data[w_pick_idx*DATA_W +: DATA_W];
      end
      if (r_state == WAIT && w_next == DONE) begin
        r_done <= NUM_REQ'(1) << r_grant;
      end
      if (r_state == DONE) begin
        r_last <= r_grant;
      end
    end
  end

  assign bus.txd_en   = r_txd_en;
  assign bus.txd_data = r_txd_data;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.grant_id = r_grant;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the single `uart_tx` transmitter among several word-producing requesters (RX echo path, status reporter, VGA-side debug dump). Sits between the requesters and `uart_tx` in the 100 MHz `clk100mhz` domain. It latches one requester's 32-bit word, pulses `txd_en`, waits for `txd_flag` completion, acknowledges the requester, then rotates priority.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: word width, equal to the `uart_tx` `txd_data` width.
- `TIMEOUT_CYC`, 1_000_000: watchdog limit in `clk` cycles (10 ms at 100 MHz; one 32-bit word at 9600 bps takes about 4.2 ms). Used only under the configuration macro.

Ports:
- `clk` in 1: system clock (`clk100mhz`).
- `rst_n` in 1: asynchronous active-low reset.
- `req` in `NUM_REQ`: request level per requester. Held high until that requester's `done` pulse.
- `req_data` in `NUM_REQ*DATA_W`: packed words. Requester i occupies bits `[i*DATA_W +: DATA_W]` and holds them stable while `req[i]` is high.
- `done` out `NUM_REQ`: one-cycle, one-hot pulse to the granted requester at end of transfer.
- `txd_en` out 1: one-cycle start pulse to `uart_tx`.
- `txd_data` out `DATA_W`: registered word to `uart_tx`. Stable from launch until the next grant.
- `txd_flag` in 1: one-cycle completion pulse from `uart_tx`.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `timeout_err` out 1: one-cycle pulse when the watchdog aborts a transfer.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- **IDLE**
  - If any `req` bit is high, pick a winner by round-robin, searching upward from `last+1` mod `NUM_REQ`.
  - Register `grant_id`, latch `txd_data` from the winner's slice, go to LAUNCH.
  - If no `req` bit is high, stay in IDLE.
- **LAUNCH**: assert `txd_en` for exactly this cycle, go to WAIT.
- **WAIT**
  - Stay until `txd_flag` is seen, then go to DONE.
  - `txd_flag` is ignored in IDLE, LAUNCH and DONE, including a stray pulse in the same cycle as `txd_en`.
- **DONE**
  - Pulse `done[grant_id]`.
  - Set `last <= grant_id`.
  - Go to IDLE.
- **Withdrawn request**: if `req[grant_id]` drops mid-transfer, the transfer still completes and `done` still pulses. The requester ignores a `done` it no longer expects.
- **Request changes during a transfer**: new requests or data changes after latching have no effect on the transfer in flight.
- **Reset values**: state IDLE, `last = NUM_REQ-1` (so requester 0 wins first), `txd_en = 0`, `txd_data = 0`, `done = 0`, `grant_id = 0`, `busy = 0`, `timeout_err = 0`, watchdog counter 0.
- **Reset mid-transfer**: the FSM returns to IDLE immediately. The in-flight `uart_tx` frame is abandoned and `done` is not pulsed; requesters must re-request.

## Timing
- **Arbitration latency**: `req` high in IDLE at edge N gives a grant at N+1 (state LAUNCH), then `txd_en` high during cycle N+1 to N+2.
- **Completion**: `txd_flag` seen at edge M gives `done` high during M+1 to M+2, and IDLE at M+2.
- **Back-to-back requests**: the next grant is at M+3. Minimum overhead between transfers is 4 cycles, excluding `uart_tx` time.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- **Defined**:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYC-1` without `txd_flag`, pulse `timeout_err` and `done[grant_id]` in DONE, and rotate priority as normal.
  - If `txd_flag` arrives in the same cycle as the limit, it is a normal completion with no error.
- **Undefined**:
  - There is no counter; WAIT holds indefinitely.
  - `timeout_err` is tied to 0 and the port remains.

## Structure
- Package `uart_pkg`:
  - state enum `arb_state_t` (IDLE, LAUNCH, WAIT, DONE);
  - constants `UART_WORD_W = 32`;
  - `UART_DEF_TIMEOUT = 1_000_000`.
- Sub-module `uart_rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `last`.
  - Outputs: `any`, `idx`.
  - Parameterized by `NUM_REQ`.

## Test plan
- **Single request**: `req = 4'b0100`, slice 2 = `32'hDEADBEEF`. Expect `txd_en` one cycle later with `txd_data = 32'hDEADBEEF` and `grant_id = 2`. Model `txd_flag` after 50 cycles; expect `done = 4'b0100` on the next cycle.
- **Round-robin rotation**: hold `req = 4'b1111` with distinct words. Expect grant order 0, 1, 2, 3, 0 with exactly one `txd_en` per transfer.
- **Priority after grant**: `req = 4'b1001` with `last = 0`. Expect a grant to 3, then to 0.
- **Withdrawal and stray flag**: drop `req[1]` during WAIT; expect `done[1]` still pulsed. Inject `txd_flag` in the LAUNCH cycle; expect it ignored and the FSM still in WAIT.
- **Timeout (`UART_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYC = 100`)**: never send `txd_flag`. Expect `timeout_err` and `done` pulses about 100 cycles after `txd_en`, then the next requester served.
- **Reset mid-transfer**: assert `rst_n = 0` in WAIT. Expect all outputs 0, state IDLE, and on release requester 0 wins if requested.
